// File: rtl/fetch_controller.sv
// Instruction fetch controller: pc, 2-entry {pc, inst} buffer,
// flush on exception / interrupt / redirect, epc and handler tracking.
module fetch_controller #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h0000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        ret_i,
    input  logic        irq_i,
    input  logic        exc_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] epc_o,
    output logic        in_handler_o
);

    logic [31:0]       r_pc;
    logic [31:0]       r_epc;
    logic              r_in_handler;
    logic [1:0]        r_count;
    logic [1:0][31:0]  r_q_pc;
    logic [1:0][31:0]  r_q_inst;

    logic              w_pop;
    logic              w_push;
    logic              w_exc;
    logic              w_irq;
    logic              w_redir;
    logic              w_flush;
    logic              w_widx;
    logic [31:0]       w_flush_pc;
    logic [31:0]       w_epc_src;
    logic [1:0]        w_ncount;
    logic [1:0][31:0]  w_nq_pc;
    logic [1:0][31:0]  w_nq_inst;

    // Outputs are forced to their reset values while rst is held,
    // since the synchronous reset only lands at the next edge.
    always_comb begin
        rom_ce_o     = ~rst;
        rom_addr_o   = rst ? RESET_VEC : r_pc;
        inst_valid_o = ~rst & (r_count != 2'd0);
        inst_o       = inst_valid_o ? r_q_inst[0] : 32'h0;
        inst_pc_o    = inst_valid_o ? r_q_pc[0] : 32'h0;
        epc_o        = rst ? 32'h0 : r_epc;
        in_handler_o = ~rst & r_in_handler;
    end

    // Flush priority: exception, then unmasked interrupt, then redirect.
    always_comb begin
        w_pop   = inst_valid_o & inst_ready_i;
        w_exc   = exc_i;
        w_irq   = irq_i & ~r_in_handler & ~exc_i;
        w_redir = redirect_i & ~w_exc & ~w_irq;
        w_flush = w_exc | w_irq | w_redir;
        w_push  = ~w_flush & (~r_count[1] | w_pop);
        w_flush_pc = redirect_addr_i;
        if (w_exc) begin
            w_flush_pc = EXC_VEC;
        end else if (w_irq) begin
            w_flush_pc = IRQ_VEC;
        end
        w_epc_src = r_pc;
        if (redirect_i) begin
            w_epc_src = redirect_addr_i;
        end else if (r_count != 2'd0) begin
            w_epc_src = r_q_pc[0];
        end
    end

    // Buffer next state: shift on pop, then write the new word
    // into the first free slot.
    always_comb begin
        w_nq_pc   = r_q_pc;
        w_nq_inst = r_q_inst;
        w_widx    = r_count[1] | (r_count[0] & ~w_pop);
        if (w_pop) begin
            w_nq_pc[0]   = r_q_pc[1];
            w_nq_inst[0] = r_q_inst[1];
        end
        if (w_push) begin
            w_nq_pc[w_widx]   = r_pc;
            w_nq_inst[w_widx] = rom_data_i;
        end
        w_ncount = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end

    // State register: pc, buffer, epc and handler flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_VEC;
            r_epc        <= 32'h0;
            r_in_handler <= 1'b0;
            r_count      <= 2'd0;
            r_q_pc       <= '0;
            r_q_inst     <= '0;
        end else begin
            if (w_flush) begin
                r_count <= 2'd0;
                r_pc    <= w_flush_pc;
            end else begin
                r_count  <= w_ncount;
                r_q_pc   <= w_nq_pc;
                r_q_inst <= w_nq_inst;
                if (w_push) begin
                    r_pc <= r_pc + 32'd4;
                end
            end
            if (w_exc | w_irq) begin
                r_in_handler <= 1'b1;
                r_epc        <= w_epc_src;
            end else if (w_redir & ret_i) begin
                r_in_handler <= 1'b0;
            end
        end
    end

endmodule
